// File: rtl/exec_div_pkg.sv
// Shared constants, FSM encoding and helpers for the RV32M execute-stage divider.
package exec_div_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic cond, input logic [XLEN-1:0] v);
        return cond ? -v : v;
    endfunction

endpackage

// File: rtl/exec_div_core.sv
// Unsigned 32-iteration restoring divider; quotient/remainder are valid while done is high.
module divu_core
    import exec_div_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic            running;
    logic [4:0]      cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt;

    // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
        q_bit   = ~diff[XLEN];
        rem_nxt = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

    assign quotient  = {quo_q[XLEN-2:0], q_bit};
    assign remainder = rem_nxt;
    assign done      = running && (cnt == 5'd31);

    always_ff @(posedge CLK) begin
        if (RST) begin
            running <= 1'b0;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= dividend;
            dsr_q   <= divisor;
        end else if (running) begin
            rem_q <= rem_nxt;
            quo_q <= quotient;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) running <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_div.sv
// Execute-stage DIV/DIVU/REM/REMU unit: decode, sign handling, fast path, FSM and result register.
module exec_div
    import exec_div_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            STALL,
    input  logic            SCHEDULE_1ST_VALID,
    input  logic [31:0]     SCHEDULE_1ST_PC,
    input  logic [6:0]      SCHEDULE_1ST_OPCODE,
    input  logic [4:0]      SCHEDULE_1ST_RD,
    input  logic [2:0]      SCHEDULE_1ST_FUNCT3,
    input  logic [6:0]      SCHEDULE_1ST_FUNCT7,
    input  logic [XLEN-1:0] REG_RS1_DATA,
    input  logic [XLEN-1:0] REG_RS2_DATA,
    output logic            DIV_STALL,
    output logic            DIV_VALID,
    output logic [31:0]     DIV_PC,
    output logic [4:0]      DIV_RD,
    output logic [XLEN-1:0] DIV_DATA
);

    div_state_e      state_q, state_d;
    logic            is_div, is_signed, is_rem, div_zero, overflow, fast;
    logic            accept, core_start, core_done;
    logic [XLEN-1:0] fast_data, rs1_abs, rs2_abs, core_quo, core_rem;
    logic [31:0]     pc_op;
    logic [4:0]      rd_op;
    logic            rem_op, neg_quo, neg_rem;

    always_comb begin
        is_div    = SCHEDULE_1ST_VALID && (SCHEDULE_1ST_OPCODE == OPCODE_OP)
                    && (SCHEDULE_1ST_FUNCT7 == FUNCT7_MULDIV)
                    && (SCHEDULE_1ST_FUNCT3 inside {FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU});
        is_signed = (SCHEDULE_1ST_FUNCT3 == FUNCT3_DIV) || (SCHEDULE_1ST_FUNCT3 == FUNCT3_REM);
        is_rem    = (SCHEDULE_1ST_FUNCT3 == FUNCT3_REM) || (SCHEDULE_1ST_FUNCT3 == FUNCT3_REMU);
        div_zero  = (REG_RS2_DATA == '0);
        overflow  = is_signed && (REG_RS1_DATA == 32'h8000_0000) && (REG_RS2_DATA == 32'hFFFF_FFFF);
        fast      = div_zero || overflow;
        if (div_zero) fast_data = is_rem ? REG_RS1_DATA : 32'hFFFF_FFFF;
        else          fast_data = is_rem ? 32'h0000_0000 : 32'h8000_0000;
        rs1_abs   = neg_if(is_signed && REG_RS1_DATA[XLEN-1], REG_RS1_DATA);
        rs2_abs   = neg_if(is_signed && REG_RS2_DATA[XLEN-1], REG_RS2_DATA);
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = fast ? DONE : BUSY;
                BUSY:    if (core_done) state_d = DONE;
                DONE:    if (!STALL) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        DIV_VALID  = (state_q == DONE);
        DIV_STALL  = ((state_q == IDLE) && is_div && !FLUSH) || (state_q == BUSY);
        accept     = (state_q == IDLE) && is_div && !FLUSH && !STALL;
        core_start = accept && !fast;
    end

    divu_core u_core (
        .CLK       (CLK),
        .RST       (RST),
        .start     (core_start),
        .abort     (FLUSH),
        .dividend  (rs1_abs),
        .divisor   (rs2_abs),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // Outputs only change on entry to DONE so they hold steady while STALL keeps us there
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_op    <= '0;
            rd_op    <= '0;
            rem_op   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            DIV_PC   <= '0;
            DIV_RD   <= '0;
            DIV_DATA <= '0;
        end else if (accept) begin
            pc_op   <= SCHEDULE_1ST_PC;
            rd_op   <= SCHEDULE_1ST_RD;
            rem_op  <= is_rem;
            neg_quo <= is_signed && (REG_RS1_DATA[XLEN-1] ^ REG_RS2_DATA[XLEN-1]);
            neg_rem <= is_signed && REG_RS1_DATA[XLEN-1];
            if (fast) begin
                DIV_PC   <= SCHEDULE_1ST_PC;
                DIV_RD   <= SCHEDULE_1ST_RD;
                DIV_DATA <= fast_data;
            end
        end else if ((state_q == BUSY) && core_done && !FLUSH) begin
            DIV_PC   <= pc_op;
            DIV_RD   <= rd_op;
            DIV_DATA <= rem_op ? neg_if(neg_rem, core_rem) : neg_if(neg_quo, core_quo);
        end
    end

endmodule

// File: doc/exec_div.md
# exec_div

Multi-cycle RV32M divide unit in the execute stage, directly downstream of the first schedule stage. It consumes the scheduled instruction plus register-read operands and computes DIV/DIVU/REM/REMU over 32 iterations. While it works, it stalls the upstream pipeline, then emits a one-cycle result tagged with PC and RD. Non-divide instructions are ignored; other execute units handle them.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  pipeline flush; abort any operation in flight.
- STALL  in  1  downstream stall; holds a completed result.
- SCHEDULE_1ST_VALID  in  1  instruction valid.
- SCHEDULE_1ST_PC  in  32  instruction PC.
- SCHEDULE_1ST_OPCODE  in  7  opcode.
- SCHEDULE_1ST_RD  in  5  destination register.
- SCHEDULE_1ST_FUNCT3  in  3  funct3.
- SCHEDULE_1ST_FUNCT7  in  7  funct7.
- REG_RS1_DATA  in  32  dividend; valid in the same cycle as the instruction.
- REG_RS2_DATA  in  32  divisor; valid in the same cycle as the instruction.
- DIV_STALL  out  1  freeze schedule stage (combinational).
- DIV_VALID  out  1  result valid.
- DIV_PC  out  32  PC of the completed op.
- DIV_RD  out  5  RD of the completed op.
- DIV_DATA  out  32  quotient or remainder.

## Operation
- Divide op is decoded when all of the following hold: VALID=1, OPCODE=7'b0110011, FUNCT7=7'b0000001, FUNCT3[2]=1.
  - FUNCT3 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
- FSM states are IDLE, BUSY and DONE. All outputs reset to 0; state resets to IDLE.
- IDLE:
  - A divide op is accepted unless FLUSH or STALL is high. Accepting latches PC, RD, funct3 and both operands.
  - Divisor == 0: go to DONE. Quotient = 32'hFFFF_FFFF; remainder = dividend.
  - Signed overflow (DIV/REM with rs1 = 32'h8000_0000, rs2 = 32'hFFFF_FFFF): go to DONE. Quotient = 32'h8000_0000; remainder = 0.
  - Otherwise: go to BUSY with counter = 0.
- BUSY:
  - Unsigned restoring division on magnitudes; signed ops use the absolute values of the operands.
  - Each cycle: shift the 33-bit partial remainder left, bring in one dividend bit MSB-first, trial-subtract the divisor, and set that quotient bit.
  - After counter reaches 31 (32 iterations), go to DONE.
- Sign fix-up on the final result:
  - DIV: negate the quotient when the operand signs differ.
  - REM: negate the remainder when the dividend is negative.
  - Unsigned ops: no fix-up.
- DONE:
  - DIV_VALID = 1. DIV_DATA is the quotient (funct3[1]=0) or the remainder (funct3[1]=1).
  - Go to IDLE when STALL = 0; otherwise hold all outputs unchanged.
- DIV_STALL = (IDLE && divide op decoded && !FLUSH) || BUSY.
  - DIV_STALL is low in DONE, so the schedule stage advances on the same edge the result leaves. The same instruction is never re-accepted.
- FLUSH in any state: go to IDLE next cycle with DIV_VALID = 0. FLUSH wins over a simultaneous accept or completion.
- RST mid-operation: identical to FLUSH, and additionally clears the datapath registers.

## Timing
- Accept edge is T0.
- Normal path: BUSY during cycles T0+1 through T0+32; DIV_VALID high in cycle T0+33. Latency is 33 cycles.
- Fast path (divide-by-zero, overflow): DIV_VALID high in cycle T0+1.
- DIV_VALID is a one-cycle pulse per op when STALL = 0. Under STALL it stays high until the first cycle with STALL = 0, inclusive.
- Back-to-back divides: the next op can be accepted in the IDLE cycle after DONE. Minimum spacing is 34 cycles on the normal path and 2 on the fast path.

## Structure
- Shared package/header holds:
  - OPCODE_OP (7'b0110011)
  - FUNCT7_MULDIV (7'b0000001)
  - FUNCT3 codes for DIV/DIVU/REM/REMU
  - FSM state encodings (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2)
- One sub-module, divu_core: unsigned 32-iteration restoring divider with start/done, 5-bit counter, and quotient/remainder outputs.
- exec_div itself holds decode, sign handling, fast path, FSM and the result register.

## Test plan
- DIVU 100 / 7 -> DIV_VALID exactly at T0+33 with DIV_DATA = 14; DIV_STALL high from T0 through T0+32.
- REM -7 / 2 -> DIV_DATA = 32'hFFFF_FFFF (-1). DIV -7 / 2 -> DIV_DATA = 32'hFFFF_FFFD (-3).
- DIV 5 / 0 -> DIV_VALID at T0+1 with 32'hFFFF_FFFF. REMU 5 / 0 -> 5.
- DIV 32'h8000_0000 / -1 -> 32'h8000_0000 at T0+1. REM of the same operands -> 0.
- FLUSH asserted at T0+10 of a DIVU -> next cycle is IDLE, DIV_STALL = 0, and no DIV_VALID ever appears for that op.
- STALL high for 3 cycles at DONE -> DIV_VALID, DIV_PC, DIV_RD and DIV_DATA stay stable for 4 cycles, then drop. An ADD instruction (funct7 = 0) presented meanwhile is never accepted.
